// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: acknowledges each receiver word, tags it with error status,
// queues it in a small FIFO for a valid/ready consumer and keeps saturating error statistics.
module uart_rx_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_ready,
  input  logic                     parity_error,
  input  logic                     framing_error,
  output logic                     rx_clear,
  input  logic                     drop_on_error,
  input  logic                     clr_stats,
  output logic [WIDTH-1:0]         m_data,
  output logic [1:0]               m_err,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  output logic [CNT_W-1:0]         parity_err_cnt,
  output logic [CNT_W-1:0]         framing_err_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH+1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic capture, pop, full, err_any, err_drop, ovf_drop, wr_en;

  always_comb begin
    state_d  = state_q;
    rx_clear = 1'b0;
    unique case (state_q)
      S_IDLE:     if (rx_ready) state_d = S_ACK;
      S_ACK: begin
        rx_clear = 1'b1;
        state_d  = S_WAIT_LOW;
      end
      S_WAIT_LOW: if (!rx_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture decision: error drop outranks overrun; a same-edge pop frees the slot.
  always_comb begin
    capture  = (state_q == S_IDLE) && rx_ready;
    pop      = m_valid && m_ready;
    full     = (count_q == CW'(DEPTH));
    err_any  = parity_error || framing_error;
    err_drop = capture && drop_on_error && err_any;
    ovf_drop = capture && !err_drop && full && !pop;
    wr_en    = capture && !err_drop && !ovf_drop;
  end

  always_comb begin
    wptr_d  = wr_en ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop   ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q + CW'(wr_en) - CW'(pop);
  end

  always_comb begin
    overrun_d  = overrun_q;
    par_cnt_d  = par_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_stats) begin
      overrun_d  = 1'b0;
      par_cnt_d  = '0;
      frm_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      if (ovf_drop) overrun_d = 1'b1;
      if (capture && parity_error && (par_cnt_q != '1))   par_cnt_d  = par_cnt_q + CNT_W'(1);
      if (capture && framing_error && (frm_cnt_q != '1))  frm_cnt_d  = frm_cnt_q + CNT_W'(1);
      if ((err_drop || ovf_drop) && (drop_cnt_q != '1))   drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      par_cnt_q  <= '0;
      frm_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      par_cnt_q  <= par_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= {framing_error, parity_error, rx_data};
  end

  assign m_data          = mem_q[rptr_q][WIDTH-1:0];
  assign m_err           = mem_q[rptr_q][WIDTH+1:WIDTH];
  assign m_valid         = (count_q != '0);
  assign fifo_count      = count_q;
  assign overrun         = overrun_q;
  assign parity_err_cnt  = par_cnt_q;
  assign framing_err_cnt = frm_cnt_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=4, CNT_W=2 so saturation is reachable).
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_ready = 1'b0;
  logic        parity_error = 1'b0;
  logic        framing_error = 1'b0;
  logic        rx_clear;
  logic        drop_on_error = 1'b0;
  logic        clr_stats = 1'b0;
  logic [31:0] m_data;
  logic [1:0]  m_err;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic [1:0]  parity_err_cnt;
  logic [1:0]  framing_err_cnt;
  logic [1:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int clear_total = 0;

  uart_rx_ctrl #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .parity_error(parity_error), .framing_error(framing_error), .rx_clear(rx_clear),
    .drop_on_error(drop_on_error), .clr_stats(clr_stats), .m_data(m_data), .m_err(m_err),
    .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count), .overrun(overrun),
    .parity_err_cnt(parity_err_cnt), .framing_err_cnt(framing_err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // rx_clear is high for a whole cycle at most, so one negedge sample per cycle counts pulses.
  always @(negedge clk) if (rx_clear) clear_total++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_ready = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
    drop_on_error = 1'b0; clr_stats = 1'b0; m_ready = 1'b0; rx_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic par, input logic frm);
    rx_data = d; parity_error = par; framing_error = frm; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rx_clear, m_valid, fifo_count, overrun} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: actual clr=%b valid=%b cnt=%0d ovr=%b required all 0",
               rx_clear, m_valid, fifo_count, overrun);
    end
    checks++;
    if ({parity_err_cnt, framing_err_cnt, drop_cnt} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_counters: actual %0d %0d %0d required 0 0 0",
               parity_err_cnt, framing_err_cnt, drop_cnt);
    end
  endtask

  task automatic test_single_word();
    int snap;
    do_reset();
    snap = clear_total;
    rx_data = 32'hDEADBEEF; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checks++;
    if (rx_clear !== 1'b1) begin
      errors++; $display("[TB] FAIL single_clear_e1: actual=%b required=1", rx_clear);
    end
    checks++;
    if ({m_valid, m_data, m_err, fifo_count} !== {1'b1, 32'hDEADBEEF, 2'b00, 3'd1}) begin
      errors++;
      $display("[TB] FAIL single_head: actual valid=%b data=%h err=%b cnt=%0d required 1 deadbeef 00 1",
               m_valid, m_data, m_err, fifo_count);
    end
    tick();
    checks++;
    if (rx_clear !== 1'b0) begin
      errors++; $display("[TB] FAIL single_clear_e2: actual=%b required=0", rx_clear);
    end
    tick(); tick();
    checks++;
    if (clear_total - snap !== 1) begin
      errors++; $display("[TB] FAIL single_pulses: actual=%0d required=1", clear_total - snap);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if ({m_valid, fifo_count} !== {1'b0, 3'd0}) begin
      errors++; $display("[TB] FAIL single_pop: actual valid=%b cnt=%0d required 0 0", m_valid, fifo_count);
    end
  endtask

  task automatic test_level_hold();
    int snap;
    do_reset();
    snap = clear_total;
    rx_data = 32'h1; rx_ready = 1'b1;
    repeat (10) tick();
    rx_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (clear_total - snap !== 1) begin
      errors++; $display("[TB] FAIL level_pulses: actual=%0d required=1", clear_total - snap);
    end
    checks++;
    if ({fifo_count, m_data} !== {3'd1, 32'h1}) begin
      errors++; $display("[TB] FAIL level_count: actual cnt=%0d data=%h required 1 00000001", fifo_count, m_data);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 1; i <= 5; i++) send_word(32'(i), 1'b0, 1'b0);
    checks++;
    if ({fifo_count, overrun, drop_cnt} !== {3'd4, 1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL overrun_state: actual cnt=%0d ovr=%b drop=%0d required 4 1 1",
               fifo_count, overrun, drop_cnt);
    end
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({m_valid, m_data} !== {1'b1, 32'(i)}) begin
        errors++; $display("[TB] FAIL overrun_drain: actual valid=%b data=%0d required 1 %0d", m_valid, m_data, i);
      end
      tick();
    end
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL overrun_empty: actual=%b required=0", m_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_q [4];
    exp_q = '{32'd6, 32'd7, 32'd8, 32'd9};
    do_reset();
    for (int i = 5; i <= 8; i++) send_word(32'(i), 1'b0, 1'b0);
    rx_data = 32'd9; rx_ready = 1'b1; m_ready = 1'b1;
    tick();
    rx_ready = 1'b0; m_ready = 1'b0;
    checks++;
    if ({overrun, fifo_count, drop_cnt} !== {1'b0, 3'd4, 2'd0}) begin
      errors++;
      $display("[TB] FAIL fullpop_state: actual ovr=%b cnt=%0d drop=%0d required 0 4 0",
               overrun, fifo_count, drop_cnt);
    end
    tick(); tick();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({m_valid, m_data} !== {1'b1, exp_q[i]}) begin
        errors++;
        $display("[TB] FAIL fullpop_drain: actual valid=%b data=%0d required 1 %0d", m_valid, m_data, exp_q[i]);
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    drop_on_error = 1'b0;
    send_word(32'hA, 1'b1, 1'b0);
    drop_on_error = 1'b1;
    send_word(32'hB, 1'b0, 1'b1);
    drop_on_error = 1'b0;
    checks++;
    if ({fifo_count, m_data, m_err} !== {3'd1, 32'hA, 2'b01}) begin
      errors++;
      $display("[TB] FAIL err_queue: actual cnt=%0d data=%h err=%b required 1 0000000a 01",
               fifo_count, m_data, m_err);
    end
    checks++;
    if ({parity_err_cnt, framing_err_cnt, drop_cnt} !== {2'd1, 2'd1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL err_counts: actual %0d %0d %0d required 1 1 1",
               parity_err_cnt, framing_err_cnt, drop_cnt);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int i = 0; i < 5; i++) send_word(32'(32'h100 + i), 1'b1, 1'b0);
    checks++;
    if ({parity_err_cnt, overrun, drop_cnt, fifo_count} !== {2'd3, 1'b1, 2'd1, 3'd4}) begin
      errors++;
      $display("[TB] FAIL sat_state: actual par=%0d ovr=%b drop=%0d cnt=%0d required 3 1 1 4",
               parity_err_cnt, overrun, drop_cnt, fifo_count);
    end
    rx_data = 32'h200; parity_error = 1'b1; rx_ready = 1'b1; clr_stats = 1'b1;
    tick();
    rx_ready = 1'b0; parity_error = 1'b0; clr_stats = 1'b0;
    checks++;
    if ({parity_err_cnt, overrun, drop_cnt, fifo_count} !== {2'd0, 1'b0, 2'd0, 3'd4}) begin
      errors++;
      $display("[TB] FAIL clear_wins: actual par=%0d ovr=%b drop=%0d cnt=%0d required 0 0 0 4",
               parity_err_cnt, overrun, drop_cnt, fifo_count);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    rx_data = 32'h300; rx_ready = 1'b1;
    tick();
    checks++;
    if (rx_clear !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_pre: actual clr=%b required=1", rx_clear);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_clear, m_valid, fifo_count, overrun, parity_err_cnt, drop_cnt} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: actual clr=%b valid=%b cnt=%0d ovr=%b par=%0d drop=%0d required all 0",
               rx_clear, m_valid, fifo_count, overrun, parity_err_cnt, drop_cnt);
    end
    rx_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_level_hold();
    test_overrun();
    test_full_pop();
    test_errors();
    test_saturation_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between the 32-bit UART receiver and the system consumer. It detects each completed word from the receiver and acknowledges it with `rx_clear`. It tags each word with its parity/framing status and queues it in a small FIFO. Words are delivered over a valid/ready stream. It also keeps saturating error/overrun statistics and can optionally discard errored words.

## Interface
- `WIDTH`, 32: data word width; must match the receiver.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of each statistics counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  WIDTH  word from receiver.
- `rx_ready`  in  1  receiver word-complete flag; pulse or level.
- `parity_error`  in  1  receiver parity flag; valid with `rx_ready`.
- `framing_error`  in  1  receiver stop-bit flag; valid with `rx_ready`.
- `rx_clear`  out  1  one-cycle acknowledge to receiver.
- `drop_on_error`  in  1  1 = words with any error are counted but not queued.
- `clr_stats`  in  1  synchronous clear of counters and `overrun`.
- `m_data`  out  WIDTH  head-of-FIFO word.
- `m_err`  out  2  head-of-FIFO tag: {framing, parity}.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts head when `m_valid`=1.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `overrun`  out  1  sticky: a word was lost because the FIFO was full.
- `parity_err_cnt`  out  CNT_W  saturating count of words with parity error.
- `framing_err_cnt`  out  CNT_W  saturating count of words with framing error.
- `drop_cnt`  out  CNT_W  saturating count of words not queued, for overrun or error drop.

## Operation
- FSM states: `S_IDLE`, `S_ACK`, `S_WAIT_LOW`.
  - `S_IDLE`: when `rx_ready`=1, capture `rx_data` and both error flags at this edge, then go to `S_ACK`.
  - `S_ACK`: `rx_clear`=1 for exactly this state (Moore output). Go to `S_WAIT_LOW` unconditionally.
  - `S_WAIT_LOW`: wait until `rx_ready`=0, then go to `S_IDLE`. This guarantees one capture per word when `rx_ready` is held as a level.
- Capture decision at the capture edge, in priority order:
  - If `drop_on_error`=1 and (parity|framing): do not write; increment `drop_cnt`.
  - Else if FIFO is full and no pop occurs this edge: do not write; set `overrun`; increment `drop_cnt`.
  - Else: write {framing, parity, data} at the write pointer.
- Error counters increment on every captured word with the corresponding flag, whether or not the word is queued.
- Pop occurs on any edge with `m_valid`=1 and `m_ready`=1; the read pointer advances.
- Full FIFO with simultaneous write and pop: both happen, occupancy unchanged, no overrun.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `fifo_count` ranges from 0 to DEPTH.
- Counters saturate at all-ones and never wrap.
- `clr_stats`=1 zeroes all three counters and `overrun`. A clear wins over a same-cycle increment or overrun set. `clr_stats` does not affect the FIFO or the FSM.
- `m_data`/`m_err` show the head entry; their value is don't-care when `m_valid`=0.

## Timing
- Reset values: FSM=`S_IDLE`, `rx_clear`=0, `m_valid`=0, `fifo_count`=0, `overrun`=0, all counters=0, pointers=0. FIFO contents are don't-care.
- Reset asserted mid-operation: FIFO emptied, in-flight word discarded, `rx_clear` deasserts immediately (asynchronously).
- Capture at edge E (`rx_ready` sampled 1 in `S_IDLE`):
  - `rx_clear`=1 during cycle E+1 only.
  - `fifo_count` and `m_valid` update after E: when the FIFO was empty, `m_valid`=1 in cycle E+1.
  - Counters and `overrun` update after edge E.
- Pop at edge P: the new head, or `m_valid`=0, is visible after P. The consumer may pop every cycle.
- Minimum capture spacing is 3 cycles (IDLE→ACK→WAIT_LOW→IDLE, when `rx_ready` is already low).

## Test plan
- Single word: inject 0xDEADBEEF with a 1-cycle `rx_ready` pulse and no errors, `m_ready`=0. Required: exactly one `rx_clear` pulse in the next cycle; `m_valid`=1, `m_data`=0xDEADBEEF, `m_err`=0, `fifo_count`=1. Then `m_ready`=1 for one cycle → `m_valid`=0.
- Level hold: hold `rx_ready`=1 for 10 cycles with word 0x1. Required: one capture, one `rx_clear` pulse, `fifo_count`=1.
- Overrun: 5 words 1..5 with DEPTH=4 and `m_ready`=0. Required: `fifo_count`=4, `overrun`=1, `drop_cnt`=1; the drain order is 1,2,3,4.
- Full plus simultaneous pop: FIFO full with `m_ready`=1 on the capture edge of word 9. Required: no overrun, `fifo_count` stays 4, word 9 is drained last.
- Errors: word A with parity error and `drop_on_error`=0, then word B with framing error and `drop_on_error`=1. Required: A queued with `m_err`=01, B not queued; `parity_err_cnt`=1, `framing_err_cnt`=1, `drop_cnt`=1.
- Saturation/clear, with CNT_W=2: 5 parity-error words. Required: `parity_err_cnt` stays at 3. Then pulse `clr_stats` on the same edge as a 6th errored capture. Required: count=0, `overrun`=0. Also assert `rst_n` low mid-queue. Required: all outputs at reset values immediately.
